// File: rtl/multi_clock_divider.sv
// N-channel programmable clock/tick divider: each channel produces a registered
// divided clock and a one-cycle tick per period, with deferred divisor reloads.
module multi_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 100_000_000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_CH-1:0]         i_enable,
    input  logic                      i_clear,
    input  logic [NUM_CH-1:0]         i_load,
    input  logic [NUM_CH*DIV_W-1:0]   i_div,
    output logic [NUM_CH-1:0]         o_clk,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH*DIV_W-1:0]   o_div_active
);

    localparam logic [DIV_W-1:0] RESET_DIV =
        (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    // Divisors below 2 cannot form a period with both clock phases.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        clamp_div = (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] r_cnt, r_div, r_pend;
        logic             r_pend_valid, r_clk, r_tick;
        logic [DIV_W-1:0] w_cnt_nxt, w_div_nxt, w_pend_nxt, w_div_in;
        logic             w_pend_valid_nxt, w_tick_nxt, w_wrap, w_clk_nxt;

        assign w_div_in  = clamp_div(i_div[k*DIV_W +: DIV_W]);
        assign w_wrap    = (r_cnt >= r_div - DIV_W'(1));
        // Clock is low for the first ceil(N/2) counts of each period.
        assign w_clk_nxt = (w_cnt_nxt >= (w_div_nxt - (w_div_nxt >> 1)));

        // Next-state: clear beats load-while-idle beats counting.
        always_comb begin
            w_cnt_nxt        = r_cnt;
            w_div_nxt        = r_div;
            w_pend_nxt       = r_pend;
            w_pend_valid_nxt = r_pend_valid;
            w_tick_nxt       = 1'b0;
            if (i_clear) begin
                w_cnt_nxt        = '0;
                w_pend_valid_nxt = 1'b0;
                if (i_load[k]) begin
                    w_div_nxt = w_div_in;
                end else if (r_pend_valid) begin
                    w_div_nxt = r_pend;
                end else begin
                    w_div_nxt = r_div;
                end
            end else if (i_load[k] && !i_enable[k]) begin
                w_cnt_nxt        = '0;
                w_div_nxt        = w_div_in;
                w_pend_valid_nxt = 1'b0;
            end else if (i_enable[k]) begin
                if (w_wrap) begin
                    w_cnt_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    if (r_pend_valid) begin
                        w_div_nxt = r_pend;
                    end else begin
                        w_div_nxt = r_div;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
                // A load while running waits for the next wrap so no period is cut short.
                if (i_load[k]) begin
                    w_pend_nxt       = w_div_in;
                    w_pend_valid_nxt = 1'b1;
                end else if (w_wrap) begin
                    w_pend_valid_nxt = 1'b0;
                end else begin
                    w_pend_valid_nxt = r_pend_valid;
                end
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end

        // Channel state registers.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_cnt        <= '0;
                r_div        <= RESET_DIV;
                r_pend       <= '0;
                r_pend_valid <= 1'b0;
                r_clk        <= 1'b0;
                r_tick       <= 1'b0;
            end else begin
                r_cnt        <= w_cnt_nxt;
                r_div        <= w_div_nxt;
                r_pend       <= w_pend_nxt;
                r_pend_valid <= w_pend_valid_nxt;
                r_clk        <= w_clk_nxt;
                r_tick       <= w_tick_nxt;
            end
        end

        assign o_clk[k]                       = r_clk;
        assign o_tick[k]                      = r_tick;
        assign o_div_active[k*DIV_W +: DIV_W] = r_div;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: a period-level reference model checked
// every cycle, plus hand-computed tick times and reset/clear values.
module tb_multi_clock_divider;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int DEF = 10;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b0;
    logic [NCH-1:0]      i_enable = '0;
    logic                i_clear = 1'b0;
    logic [NCH-1:0]      i_load = '0;
    logic [NCH*DW-1:0]   i_div = '0;
    logic [NCH-1:0]      o_clk;
    logic [NCH-1:0]      o_tick;
    logic [NCH*DW-1:0]   o_div_active;

    multi_clock_divider #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_load(i_load), .i_div(i_div), .o_clk(o_clk), .o_tick(o_tick),
        .o_div_active(o_div_active)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int m_cnt[NCH]  = '{0, 0, 0, 0};
    int m_div[NCH]  = '{DEF, DEF, DEF, DEF};
    int m_pend[NCH] = '{0, 0, 0, 0};
    bit m_pv[NCH]   = '{0, 0, 0, 0};
    bit m_clk[NCH]  = '{0, 0, 0, 0};
    bit m_tick[NCH] = '{0, 0, 0, 0};
    int first_after[NCH] = '{-2, -2, -2, -2};
    int tick_q[$];
    bit rec_q = 1'b0;

    // Cycle index: number of rising edges since reset released.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Reference model: position within the current period, per channel.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NCH; k++) begin
                m_cnt[k] <= 0; m_div[k] <= DEF; m_pend[k] <= 0; m_pv[k] <= 1'b0;
                m_clk[k] <= 1'b0; m_tick[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                automatic int din = int'(i_div[k*DW +: DW]);
                automatic int c = m_cnt[k];
                automatic int d = m_div[k];
                automatic int p = m_pend[k];
                automatic bit v = m_pv[k];
                automatic bit t = 1'b0;
                if (din < 2) din = 2;
                if (i_clear) begin
                    c = 0;
                    if (i_load[k]) d = din;
                    else if (v) d = p;
                    v = 1'b0;
                end else if (i_load[k] && !i_enable[k]) begin
                    c = 0; d = din; v = 1'b0;
                end else if (i_enable[k]) begin
                    c = c + 1;
                    if (c == d) begin
                        c = 0; t = 1'b1;
                        if (v) d = p;
                        v = 1'b0;
                    end
                    if (i_load[k]) begin p = din; v = 1'b1; end
                end
                m_cnt[k] <= c; m_div[k] <= d; m_pend[k] <= p; m_pv[k] <= v;
                m_tick[k] <= t; m_clk[k] <= (c >= (d + 1) / 2);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, plus tick-time capture.
    initial begin
        forever begin
            @(negedge i_clk);
            for (int k = 0; k < NCH; k++) begin
                n_vec++;
                if ($isunknown({o_clk[k], o_tick[k], o_div_active[k*DW +: DW]}) ||
                    o_clk[k] != m_clk[k] || o_tick[k] != m_tick[k] ||
                    int'(o_div_active[k*DW +: DW]) != m_div[k]) begin
                    n_err++;
                    $display("FAIL model ch%0d cyc%0d: clk=%b tick=%b div=%0d, expected clk=%b tick=%b div=%0d",
                             k, cyc, o_clk[k], o_tick[k], o_div_active[k*DW +: DW],
                             m_clk[k], m_tick[k], m_div[k]);
                end
                if (o_tick[k] === 1'b1 && first_after[k] == -1) first_after[k] = cyc;
            end
            if (rec_q && o_tick[0] === 1'b1) tick_q.push_back(cyc);
        end
    end

    initial begin
        int exp_t[6] = '{10, 20, 30, 40, 45, 50};
        int c0;
        #2 i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        check("reset_clk", int'(o_clk), 0);
        check("reset_div0", int'(o_div_active[DW-1:0]), DEF);

        // Default divisor 10 on ch0, then mid-period reload to 5 at cnt=3.
        i_reset = 1'b0; i_enable = 4'b0001; rec_q = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge i_clk);
            if (i == 4) check("n10_clk_low_c4", int'(o_clk[0]), 0);
            if (i == 5) check("n10_clk_high_c5", int'(o_clk[0]), 1);
        end
        i_load = 4'b0001; i_div[DW-1:0] = 16'd5;
        @(negedge i_clk);
        i_load = 4'b0000;
        repeat (16) @(negedge i_clk);
        rec_q = 1'b0;
        check("tick_count", tick_q.size(), 6);
        for (int i = 0; i < 6 && i < tick_q.size(); i++) check("tick_time", tick_q[i], exp_t[i]);
        check("div_after_reload", int'(o_div_active[DW-1:0]), 5);

        // Loads of 0 and 1 while disabled clamp to 2 and restart the phase.
        repeat (3) @(negedge i_clk);
        check("n5_clk_high_cnt3", int'(o_clk[0]), 1);
        i_enable = 4'b0000; i_load = 4'b0001; i_div[DW-1:0] = 16'd0;
        @(negedge i_clk);
        check("load0_clk", int'(o_clk[0]), 0);
        check("load0_div", int'(o_div_active[DW-1:0]), 2);
        i_div[DW-1:0] = 16'd1;
        @(negedge i_clk);
        check("load1_div", int'(o_div_active[DW-1:0]), 2);
        i_load = 4'b0000; i_enable = 4'b0001;
        repeat (6) @(negedge i_clk);

        // Pause at cnt=4 of N=10 for 7 cycles; tick 6 enabled cycles after resume.
        i_enable = 4'b0000; i_load = 4'b0001; i_div[DW-1:0] = 16'd10;
        @(negedge i_clk);
        i_load = 4'b0000; i_enable = 4'b0001;
        repeat (4) @(negedge i_clk);
        i_enable = 4'b0000;
        repeat (7) @(negedge i_clk);
        check("paused_clk", int'(o_clk[0]), 0);
        i_enable = 4'b0001; first_after[0] = -1; c0 = cyc;
        repeat (8) @(negedge i_clk);
        check("resume_tick", first_after[0], c0 + 6);

        // Four rates, then a clear realigns every channel.
        i_enable = 4'b0000; i_load = 4'b1111;
        i_div = {16'd10, 16'd8, 16'd6, 16'd4};
        @(negedge i_clk);
        i_load = 4'b0000; i_enable = 4'b1111;
        repeat (13) @(negedge i_clk);
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0; c0 = cyc;
        check("clear_clk", int'(o_clk), 0);
        check("clear_tick", int'(o_tick), 0);
        for (int k = 0; k < NCH; k++) first_after[k] = -1;
        repeat (11) @(negedge i_clk);
        check("clear_ch0", first_after[0], c0 + 4);
        check("clear_ch1", first_after[1], c0 + 6);
        check("clear_ch2", first_after[2], c0 + 8);
        check("clear_ch3", first_after[3], c0 + 10);

        // Pending load then asynchronous reset between edges.
        i_load = 4'b0001; i_div[DW-1:0] = 16'd7;
        @(negedge i_clk);
        i_load = 4'b0000;
        repeat (2) @(negedge i_clk);
        @(posedge i_clk);
        #3 i_reset = 1'b1;
        #1;
        check("async_rst_clk", int'(o_clk), 0);
        check("async_rst_tick", int'(o_tick), 0);
        for (int k = 0; k < NCH; k++) check("async_rst_div", int'(o_div_active[k*DW +: DW]), DEF);
        @(negedge i_clk);
        i_reset = 1'b0; i_enable = 4'b0001; first_after[0] = -1;
        repeat (12) @(negedge i_clk);
        check("post_rst_tick", first_after[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
Parametrised N-channel clock/tick divider. Each channel has its own runtime-programmable divisor, enable, glitch-free registered divided clock and single-cycle tick strobe. A shared synchronous clear phase-aligns all channels. It replaces fixed single-rate dividers and feeds display scan, debounce and counter-rate logic from the 100 MHz system clock.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DIV_W, 32, divisor and counter width per channel
DEFAULT_DIV, 100_000_000, active divisor loaded at reset for every channel (1 Hz at 100 MHz)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous, active-high reset
i_enable  input  NUM_CH  per-channel count enable
i_clear  input  1  synchronous clear of all channel counters (phase align)
i_load  input  NUM_CH  per-channel divisor load strobe
i_div  input  NUM_CH*DIV_W  divisor values; channel k uses bits [k*DIV_W +: DIV_W]
o_clk  output  NUM_CH  registered divided clock per channel
o_tick  output  NUM_CH  one-i_clk-cycle strobe per divided period
o_div_active  output  NUM_CH*DIV_W  divisor currently in use per channel

Behaviour:
- Reset (async, i_reset=1): cnt=0, pend_valid=0, active div=DEFAULT_DIV, o_clk=0, o_tick=0 for all channels.
- Reset mid-operation: immediate return to reset state regardless of phase; no tick generated.
- Divisor N = active divisor; values 0 and 1 clamped to 2 on capture (stored and read back as 2).
- Per channel, enabled edge: cnt <= (cnt==N-1) ? 0 : cnt+1.
- o_tick <= 1 on the edge where cnt wraps N-1 -> 0, else 0. First tick on the Nth enabled edge after reset/clear. Exactly one tick every N enabled cycles.
- o_clk is registered and always equals (cnt >= ceil(N/2)). Low for ceil(N/2) cycles, high for floor(N/2) cycles. Exact 50% duty for even N. N=2 toggles every cycle.
- Period of o_clk and o_tick is exactly N i_clk cycles while enabled; no glitches.
- i_enable[k]=0: cnt and o_clk hold their value, o_tick=0. Resuming continues from the held cnt.
- i_load[k]=1 while the channel is enabled: the clamped i_div slice goes into a pending register (pend_valid=1). It becomes active on the next wrap edge, and that wrap still ticks. The new period starts from cnt=0, so the current period is never truncated. A later load before the wrap overwrites the pending value.
- i_load[k]=1 while the channel is disabled: the divisor becomes active immediately, cnt=0, o_clk=0, pend_valid=0.
- i_clear=1: all channels get cnt=0, o_clk=0, o_tick=0, regardless of enable. Clear beats wrap: no tick on that edge. A pending divisor is applied at the clear. A simultaneous i_load is captured and applied on the same edge.
- o_div_active reflects the active (not pending) divisor one cycle after it takes effect. It is registered, never combinational from i_div.
- Channels are fully independent apart from the shared i_clear. No output is combinational from any input.

Test Plan:
- Reset release, ch0 enabled with DEFAULT_DIV overridden to 10 -> o_tick[0] high on cycles 10, 20, 30; o_clk[0] low for 5 cycles then high for 5; o_div_active=10.
- Load N=5 while enabled mid-period (cnt=3 of N=10) -> current period completes with a tick at cycle 10; subsequent ticks every 5 cycles; o_clk 3 cycles low, 2 high.
- Load N=0 and N=1 while disabled -> o_div_active reads 2; o_clk toggles every cycle, o_tick every 2nd cycle; load resets cnt and o_clk to 0.
- Drop enable for 7 cycles at cnt=4 (N=10) -> o_clk and cnt frozen, no ticks; tick arrives 6 enabled cycles after resume.
- Four channels with N=4, 6, 8, 10 running, then i_clear pulse -> all o_clk=0 next cycle, no tick on clear edge; ticks realign at 4, 6, 8, 10 cycles after clear.
- Assert i_reset asynchronously between clock edges mid-period -> outputs go 0 immediately, o_div_active returns to DEFAULT_DIV, pending load discarded.
